// File: rtl/l1_d_controller_nway.sv
// N-way set-associative write-back L1 data-cache controller with tree-PLRU victims and flush.
// Optional L1D_STATS_EN adds saturating hit/miss/write-back counters.
// state   | meaning
// IDLE    | serve hits, detect misses and flush edges
// WB      | write dirty victim back to L2
// ALLOC   | fetch line from L2
// REFILL  | write fetched line into the data array
// FL_SCAN | walk (set, way) looking for dirty lines
// FL_WB   | write dirty scanned line back to L2
// FL_DONE | pulse flush_done
module l1_d_controller_nway #(
  parameter int TAG_W   = 52,
  parameter int INDEX_W = 6,
  parameter int WAYS    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TAG_W-1:0]      tag,
  input  logic [INDEX_W-1:0]    index,
  input  logic                  read_C_L1,
  input  logic                  write_C_L1,
  input  logic                  flush,
  output logic                  stall,
  output logic                  refill,
  output logic                  update,
  output logic [((WAYS>1)?$clog2(WAYS):1)-1:0] way,
  output logic [TAG_W-1:0]      wb_tag,
  output logic [INDEX_W-1:0]    wb_index,
  output logic                  read_L1_L2,
  output logic                  write_L1_L2,
  input  logic                  ready_L2_L1,
  output logic                  flush_done
`ifdef L1D_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           wb_count
`endif
);
  localparam int SETS   = 1 << INDEX_W;
  localparam int LOG_W  = $clog2(WAYS);
  localparam int WAY_W  = (WAYS > 1) ? LOG_W : 1;
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [2:0] {IDLE, WB, ALLOC, REFILL, FL_SCAN, FL_WB, FL_DONE} state_t;
  state_t state, state_nxt;

  logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
  logic [WAYS-1:0]   valid_mem [SETS];
  logic [WAYS-1:0]   dirty_mem [SETS];
  logic [PLRU_W-1:0] plru_mem  [SETS];

  logic [WAY_W-1:0]   victim, victim_c, hit_way, inv_way, plru_way, scan_way;
  logic [INDEX_W-1:0] miss_set, scan_set;
  logic [TAG_W-1:0]   miss_tag;
  logic hit, inv_found, req, flush_q, flush_pend, flush_edge, flush_req;
  logic victim_dirty, entry_dirty, scan_last, scan_adv, flush_clear;

  // Each tree node points toward the colder half; touching a way points its path away from it.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] old,
                                                   input logic [WAY_W-1:0] w);
    logic [PLRU_W-1:0] res;
    int node;
    res  = old;
    node = 0;
    for (int l = 0; l < LOG_W; l++) begin
      res[node] = ~w[LOG_W-1-l];
      node      = 2 * node + 1 + int'(w[LOG_W-1-l]);
    end
    return res;
  endfunction

  assign req        = read_C_L1 | write_C_L1;
  assign flush_edge = flush & ~flush_q;
  assign flush_req  = flush_edge | flush_pend;

  always_comb begin
    int node;
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    plru_way  = '0;
    node      = 0;
    for (int w = 0; w < WAYS; w++)
      if (valid_mem[index][w] && tag_mem[index][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_mem[index][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    for (int l = 0; l < LOG_W; l++) node = 2 * node + 1 + int'(plru_mem[index][node]);
    if (WAYS > 1) plru_way = WAY_W'(node - (WAYS - 1));
    victim_c     = inv_found ? inv_way : plru_way;
    victim_dirty = valid_mem[index][victim_c] && dirty_mem[index][victim_c];
  end

  assign entry_dirty = valid_mem[scan_set][scan_way] && dirty_mem[scan_set][scan_way];
  assign scan_last   = (scan_set == {INDEX_W{1'b1}}) && (scan_way == WAY_W'(WAYS - 1));
  assign scan_adv    = (state == FL_SCAN && !entry_dirty && !scan_last) ||
                       (state == FL_WB && ready_L2_L1 && !scan_last);
  assign flush_clear = (state == FL_SCAN && !entry_dirty && scan_last) ||
                       (state == FL_WB && ready_L2_L1 && scan_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      victim     <= '0;
      miss_set   <= '0;
      miss_tag   <= '0;
      scan_set   <= '0;
      scan_way   <= '0;
      flush_q    <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      state   <= state_nxt;
      flush_q <= flush;
      if (state == IDLE) flush_pend <= 1'b0;
      else if (flush_edge) flush_pend <= 1'b1;
      if (state == IDLE && req && !hit && !flush_req) begin
        victim   <= victim_c;
        miss_set <= index;
        miss_tag <= tag;
      end
      if (state == IDLE) begin
        scan_set <= '0;
        scan_way <= '0;
      end else if (scan_adv) begin
        if (scan_way == WAY_W'(WAYS - 1)) begin
          scan_way <= '0;
          scan_set <= scan_set + 1'b1;
        end else begin
          scan_way <= scan_way + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        plru_mem[s]  <= '0;
      end
    end else if (flush_clear) begin
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        plru_mem[s]  <= '0;
      end
    end else begin
      if (state == IDLE && req && hit) begin
        plru_mem[index] <= plru_touch(plru_mem[index], hit_way);
        if (write_C_L1) dirty_mem[index][hit_way] <= 1'b1;
      end
      if (state == REFILL) begin
        valid_mem[miss_set][victim] <= 1'b1;
        dirty_mem[miss_set][victim] <= 1'b0;
        plru_mem[miss_set]          <= plru_touch(plru_mem[miss_set], victim);
      end
    end
  end

  // Tags need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (state == REFILL) tag_mem[miss_set][victim] <= miss_tag;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flush_req) state_nxt = FL_SCAN;
               else if (req && !hit) state_nxt = victim_dirty ? WB : ALLOC;
      WB:      if (ready_L2_L1) state_nxt = ALLOC;
      ALLOC:   if (ready_L2_L1) state_nxt = REFILL;
      REFILL:  state_nxt = IDLE;
      FL_SCAN: if (entry_dirty) state_nxt = FL_WB;
               else if (scan_last) state_nxt = FL_DONE;
      FL_WB:   if (ready_L2_L1) state_nxt = scan_last ? FL_DONE : FL_SCAN;
      FL_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so an abort is visible immediately.
  always_comb begin
    stall       = 1'b0;
    refill      = 1'b0;
    update      = 1'b0;
    way         = '0;
    wb_tag      = '0;
    wb_index    = '0;
    read_L1_L2  = 1'b0;
    write_L1_L2 = 1'b0;
    flush_done  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          stall  = req & ~hit;
          update = write_C_L1 & hit;
          way    = hit_way;
        end
        WB: begin
          stall       = 1'b1;
          write_L1_L2 = 1'b1;
          way         = victim;
          wb_tag      = tag_mem[miss_set][victim];
          wb_index    = miss_set;
        end
        ALLOC: begin
          stall      = 1'b1;
          read_L1_L2 = 1'b1;
          way        = victim;
        end
        REFILL: begin
          stall  = 1'b1;
          refill = 1'b1;
          way    = victim;
        end
        FL_SCAN: begin
          stall = 1'b1;
          way   = scan_way;
        end
        FL_WB: begin
          stall       = 1'b1;
          write_L1_L2 = 1'b1;
          way         = scan_way;
          wb_tag      = tag_mem[scan_set][scan_way];
          wb_index    = scan_set;
        end
        FL_DONE: begin
          stall      = 1'b1;
          flush_done = 1'b1;
        end
        default: stall = 1'b0;
      endcase
    end
  end

`ifdef L1D_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (state == IDLE && req && hit && hit_count != 32'hFFFF_FFFF)
        hit_count <= hit_count + 1'b1;
      if (state == IDLE && (state_nxt == WB || state_nxt == ALLOC) && miss_count != 32'hFFFF_FFFF)
        miss_count <= miss_count + 1'b1;
      if ((state == WB || state == FL_WB) && ready_L2_L1 && wb_count != 32'hFFFF_FFFF)
        wb_count <= wb_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_l1_d_controller_nway.sv
// Directed bench for l1_d_controller_nway (default geometry: 52-bit tag, 64 sets, 2 ways).
module tb_l1_d_controller_nway;
  logic        clk = 1'b0;
  logic        rst;
  logic [51:0] tag;
  logic [5:0]  index;
  logic        read_C_L1, write_C_L1, flush, ready_L2_L1;
  logic        stall, refill, update, read_L1_L2, write_L1_L2, flush_done;
  logic [0:0]  way;
  logic [51:0] wb_tag;
  logic [5:0]  wb_index;
`ifdef L1D_STATS_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  int checks = 0;
  int failures = 0;

  // Observations gathered by the access driver for the most recent access.
  int          wb_cnt;
  logic [51:0] last_wb_tag;
  logic [5:0]  last_wb_index;
  logic        last_wb_way;
  int          first_l2;
  logic        refill_way;
  bit          wr_seen;

  l1_d_controller_nway dut (
    .clk(clk), .rst(rst), .tag(tag), .index(index),
    .read_C_L1(read_C_L1), .write_C_L1(write_C_L1), .flush(flush),
    .stall(stall), .refill(refill), .update(update), .way(way),
    .wb_tag(wb_tag), .wb_index(wb_index),
    .read_L1_L2(read_L1_L2), .write_L1_L2(write_L1_L2),
    .ready_L2_L1(ready_L2_L1), .flush_done(flush_done)
`ifdef L1D_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Holds a request until accepted, acking each L2 request after dly extra cycles.
  task automatic access(input logic [51:0] t, input logic [5:0] i, input bit wr,
                        input int dly, output bit missed);
    int wait_n;
    bit done;
    missed = 0; wait_n = 0; done = 0;
    wb_cnt = 0; first_l2 = 0; wr_seen = 0; refill_way = 1'b0;
    last_wb_tag = '0; last_wb_index = '0; last_wb_way = 1'b0;
    @(negedge clk);
    tag = t; index = i; write_C_L1 = wr; read_C_L1 = !wr;
    for (int cyc = 0; cyc < 300; cyc++) begin
      #1;
      if (!stall) begin
        done = 1;
        break;
      end
      missed = 1;
      if (refill) refill_way = way;
      if (write_L1_L2) wr_seen = 1;
      if (first_l2 == 0 && write_L1_L2) first_l2 = 1;
      else if (first_l2 == 0 && read_L1_L2) first_l2 = 2;
      if (write_L1_L2 || read_L1_L2) begin
        if (wait_n >= dly) begin
          ready_L2_L1 = 1'b1;
          wait_n = 0;
          if (write_L1_L2) begin
            wb_cnt++;
            last_wb_tag = wb_tag; last_wb_index = wb_index; last_wb_way = way;
          end
        end else begin
          wait_n++;
        end
      end
      @(negedge clk);
      ready_L2_L1 = 1'b0;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL access_timeout tag=%0h index=%0d stall=%b expected stall=0", t, i, stall);
    end
    @(negedge clk);
    read_C_L1 = 1'b0; write_C_L1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tag = '0; index = '0; read_C_L1 = 0; write_C_L1 = 0; flush = 0; ready_L2_L1 = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({stall, refill, update, read_L1_L2, write_L1_L2, flush_done} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b expected=000000",
               {stall, refill, update, read_L1_L2, write_L1_L2, flush_done});
    end
    checks++;
    if (way !== 1'b0 || wb_tag !== 52'h0 || wb_index !== 6'h0) begin
      failures++;
      $display("FAIL reset_fields way=%b wb_tag=%0h wb_index=%0d expected all 0", way, wb_tag, wb_index);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_stall got=%b expected=0", stall);
    end
  endtask

  task automatic test_cold_read();
    @(negedge clk);
    tag = 52'h1; index = 6'h05; read_C_L1 = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL cold_miss_stall got=%b expected=1", stall);
    end
    @(negedge clk); #1;
    checks++;
    if (read_L1_L2 !== 1'b1 || write_L1_L2 !== 1'b0 || stall !== 1'b1) begin
      failures++;
      $display("FAIL cold_alloc rd=%b wr=%b stall=%b expected rd=1 wr=0 stall=1",
               read_L1_L2, write_L1_L2, stall);
    end
    ready_L2_L1 = 1'b1;
    @(negedge clk);
    ready_L2_L1 = 1'b0;
    #1;
    checks++;
    if (refill !== 1'b1 || way !== 1'b0) begin
      failures++;
      $display("FAIL cold_refill refill=%b way=%b expected refill=1 way=0", refill, way);
    end
    @(negedge clk); #1;
    checks++;
    if (stall !== 1'b0 || refill !== 1'b0) begin
      failures++;
      $display("FAIL cold_hit stall=%b refill=%b expected stall=0 refill=0", stall, refill);
    end
    @(negedge clk);
    read_C_L1 = 1'b0;
  endtask

  task automatic test_write_hit_evict();
    bit m;
    @(negedge clk);
    tag = 52'h1; index = 6'h05; write_C_L1 = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || update !== 1'b1 || way !== 1'b0) begin
      failures++;
      $display("FAIL write_hit stall=%b update=%b way=%b expected stall=0 update=1 way=0",
               stall, update, way);
    end
    @(negedge clk);
    write_C_L1 = 1'b0;
    access(52'h2, 6'h05, 1'b0, 2, m);
    checks++;
    if (m !== 1'b1 || wr_seen !== 1'b0 || refill_way !== 1'b1) begin
      failures++;
      $display("FAIL fill_second_way missed=%b wb=%b refill_way=%b expected 1 0 1", m, wr_seen, refill_way);
    end
    access(52'h3, 6'h05, 1'b0, 2, m);
    checks++;
    if (wb_cnt != 1 || first_l2 != 1) begin
      failures++;
      $display("FAIL evict_wb_order wb_handshakes=%0d first=%0d expected 1 and 1(write first)", wb_cnt, first_l2);
    end
    checks++;
    if (last_wb_tag !== 52'h1 || last_wb_index !== 6'h05 || last_wb_way !== 1'b0) begin
      failures++;
      $display("FAIL evict_wb_fields tag=%0h index=%0d way=%b expected tag=1 index=5 way=0",
               last_wb_tag, last_wb_index, last_wb_way);
    end
  endtask

  task automatic test_plru();
    bit m;
    access(52'hA, 6'd3, 1'b0, 1, m);
    access(52'hB, 6'd3, 1'b0, 1, m);
    checks++;
    if (refill_way !== 1'b1) begin
      failures++;
      $display("FAIL plru_fill_b way got=%b expected=1", refill_way);
    end
    access(52'hA, 6'd3, 1'b0, 1, m);
    checks++;
    if (m !== 1'b0) begin
      failures++;
      $display("FAIL plru_read_a missed got=%b expected=0", m);
    end
    access(52'hC, 6'd3, 1'b0, 1, m);
    checks++;
    if (m !== 1'b1 || refill_way !== 1'b1 || wr_seen !== 1'b0) begin
      failures++;
      $display("FAIL plru_victim missed=%b way=%b wb=%b expected 1 1 0", m, refill_way, wr_seen);
    end
    access(52'hA, 6'd3, 1'b0, 1, m);
    checks++;
    if (m !== 1'b0) begin
      failures++;
      $display("FAIL plru_a_kept missed got=%b expected=0", m);
    end
  endtask

  task automatic test_flush();
    bit m, done_seen;
    int n_wb, wait_n;
    logic [5:0]  idx_seen [2];
    logic [51:0] tag_seen [2];
    access(52'h20, 6'd0, 1'b1, 1, m);
    access(52'h21, 6'd63, 1'b1, 1, m);
    n_wb = 0; wait_n = 0; done_seen = 0;
    idx_seen[0] = '1; idx_seen[1] = '1; tag_seen[0] = '0; tag_seen[1] = '0;
    @(negedge clk);
    flush = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      ready_L2_L1 = 1'b0;
      #1;
      if (flush_done) begin
        done_seen = 1;
        break;
      end
      if (write_L1_L2) begin
        if (wait_n == 4) begin
          ready_L2_L1 = 1'b1;
          if (n_wb < 2) begin
            idx_seen[n_wb] = wb_index;
            tag_seen[n_wb] = wb_tag;
          end
          n_wb++;
          wait_n = 0;
        end else begin
          wait_n++;
        end
      end
    end
    checks++;
    if (done_seen !== 1'b1 || n_wb != 2) begin
      failures++;
      $display("FAIL flush_count done=%b wb_handshakes=%0d expected done=1 wb=2", done_seen, n_wb);
    end
    checks++;
    if (idx_seen[0] !== 6'd0 || idx_seen[1] !== 6'd63 || tag_seen[0] !== 52'h20 || tag_seen[1] !== 52'h21) begin
      failures++;
      $display("FAIL flush_order idx=%0d,%0d tags=%0h,%0h expected idx=0,63 tags=20,21",
               idx_seen[0], idx_seen[1], tag_seen[0], tag_seen[1]);
    end
    @(negedge clk); #1;
    checks++;
    if (flush_done !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_done_pulse done=%b stall=%b expected 0 0", flush_done, stall);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_retrigger stall got=%b expected=0", stall);
    end
    flush = 1'b0;
    access(52'h20, 6'd0, 1'b0, 1, m);
    checks++;
    if (m !== 1'b1 || wr_seen !== 1'b0) begin
      failures++;
      $display("FAIL flush_invalid_set0 missed=%b wb=%b expected 1 0", m, wr_seen);
    end
    access(52'h21, 6'd63, 1'b0, 1, m);
    checks++;
    if (m !== 1'b1 || wr_seen !== 1'b0) begin
      failures++;
      $display("FAIL flush_invalid_set63 missed=%b wb=%b expected 1 0", m, wr_seen);
    end
  endtask

  task automatic test_reset_mid_wb();
    bit m;
    access(52'h30, 6'd7, 1'b1, 1, m);
    access(52'h31, 6'd7, 1'b1, 1, m);
    @(negedge clk);
    tag = 52'h32; index = 6'd7; read_C_L1 = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (write_L1_L2 !== 1'b1 || wb_tag !== 52'h30) begin
      failures++;
      $display("FAIL mid_wb_reached wr=%b wb_tag=%0h expected wr=1 wb_tag=30", write_L1_L2, wb_tag);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({stall, refill, update, read_L1_L2, write_L1_L2, flush_done} !== 6'b0 ||
        way !== 1'b0 || wb_tag !== 52'h0 || wb_index !== 6'h0) begin
      failures++;
      $display("FAIL async_reset ctrl=%b way=%b wb_tag=%0h wb_index=%0d expected all 0",
               {stall, refill, update, read_L1_L2, write_L1_L2, flush_done}, way, wb_tag, wb_index);
    end
    read_C_L1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    access(52'h30, 6'd7, 1'b0, 1, m);
    checks++;
    if (m !== 1'b1 || wr_seen !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_a missed=%b wb=%b expected 1 0", m, wr_seen);
    end
    access(52'h31, 6'd7, 1'b0, 1, m);
    checks++;
    if (m !== 1'b1 || wr_seen !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_b missed=%b wb=%b expected 1 0", m, wr_seen);
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit_evict();
    test_plru();
    test_flush();
    test_reset_mid_wb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
